// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: class codes, RV opcodes,
// common funct values and the load-control state enum.
package instr_encoder_pkg;

   localparam logic [2:0] CLS_R  = 3'd0;
   localparam logic [2:0] CLS_I1 = 3'd1;
   localparam logic [2:0] CLS_I2 = 3'd2;
   localparam logic [2:0] CLS_S  = 3'd3;
   localparam logic [2:0] CLS_B  = 3'd4;
   localparam logic [2:0] CLS_J  = 3'd5;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I1 = 7'b0000011;
   localparam logic [6:0] OP_I2 = 7'b0010011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_J  = 7'b1101111;

   localparam logic [6:0] F7_MUL = 7'b0000001;
   localparam logic [2:0] F3_LDB = 3'b000;
   localparam logic [2:0] F3_STB = 3'b000;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

   // True when v is representable as a w-bit two's-complement value.
   function automatic logic imm_fits(input logic [31:0] v, input int w);
      logic signed [31:0] s;
      s = $signed(v) >>> (w - 1);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake plus instruction-memory write port.
interface instr_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_cls;
   logic [2:0]        in_funct3;
   logic [6:0]        in_funct7;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [4:0]        in_rd;
   logic [31:0]       in_imm;
   logic              imem_we;
   logic              imem_ready;
   logic [ADDR_W+1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport slave (
      input  in_valid, in_cls, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm,
      input  imem_ready,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output in_valid, in_cls, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm,
      output imem_ready,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: class + fields -> 32-bit word and a legal flag.
// Optional IMM_RANGE_CHECK_EN rejects immediates that do not fit their field.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [2:0]  i_cls,
   input  logic [2:0]  i_funct3,
   input  logic [6:0]  i_funct7,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [4:0]  i_rd,
   input  logic [31:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_legal
);

   always_comb begin
      o_word  = '0;
      o_legal = 1'b1;
      case (i_cls)
         CLS_R:  o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
         CLS_I1: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I1};
         CLS_I2: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I2};
         CLS_S:  o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_S};
         CLS_B:  o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], OP_B};
         CLS_J:  o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_J};
         default: o_legal = 1'b0;
      endcase
`ifdef IMM_RANGE_CHECK_EN
      case (i_cls)
         CLS_I1, CLS_I2, CLS_S: if (!imm_fits(i_imm, 12)) o_legal = 1'b0;
         CLS_B: if (!imm_fits(i_imm, 13) || i_imm[0]) o_legal = 1'b0;
         CLS_J: if (!imm_fits(i_imm, 21) || i_imm[0]) o_legal = 1'b0;
         default: ;
      endcase
`endif
   end

`ifndef IMM_RANGE_CHECK_EN
   // Upper immediate bits are silently truncated when no range check is built in.
   logic w_unused;
   assign w_unused = ^i_imm[31:21];
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: accepts field bundles, packs them, and streams words
// to imem at consecutive byte addresses. Range checking via IMM_RANGE_CHECK_EN.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int BASE   = 0,
   parameter int DEPTH  = 256
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   instr_encoder_if.slave  bus,
   output logic [ADDR_W:0] count,
   output logic            done,
   output logic            err
);

   localparam logic [ADDR_W+1:0] BASE_ADDR = (ADDR_W+2)'(BASE);

   state_e            r_state, w_state_nxt;
   logic              r_we;
   logic [31:0]       r_wdata;
   logic [ADDR_W+1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic              r_err;

   logic [31:0]       w_word;
   logic              w_legal;
   logic [31:0]       w_inflight;
   logic              w_ready, w_acc, w_cmpl;
   logic [ADDR_W:0]   w_cnt_nxt;

   instr_pack u_pack (
      .i_cls    (bus.in_cls),
      .i_funct3 (bus.in_funct3),
      .i_funct7 (bus.in_funct7),
      .i_rs1    (bus.in_rs1),
      .i_rs2    (bus.in_rs2),
      .i_rd     (bus.in_rd),
      .i_imm    (bus.in_imm),
      .o_word   (w_word),
      .o_legal  (w_legal)
   );

   // A bundle arriving with start would be discarded by the restart, so hold it off.
   assign w_inflight = 32'(r_count) + 32'(r_we);
   assign w_ready    = (r_state == ST_RUN) && (w_inflight < 32'(DEPTH)) &&
                       (!r_we || bus.imem_ready) && !start;
   assign w_acc      = bus.in_valid && w_ready;
   assign w_cmpl     = r_we && bus.imem_ready;
   assign w_cnt_nxt  = r_count + (ADDR_W+1)'(w_cmpl);

   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = ST_RUN;
      end else if (r_state == ST_RUN && 32'(w_cnt_nxt) == 32'(DEPTH)) begin
         w_state_nxt = ST_DONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_addr  <= BASE_ADDR;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (start) begin
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_err   <= 1'b0;
         end else begin
            if (w_cmpl) begin
               r_addr  <= r_addr + (ADDR_W+2)'(4);
               r_count <= w_cnt_nxt;
            end
            if (w_acc && w_legal) begin
               r_we    <= 1'b1;
               r_wdata <= w_word;
            end else if (w_cmpl) begin
               r_we <= 1'b0;
            end
            if (w_acc && !w_legal) r_err <= 1'b1;
         end
      end
   end

   assign bus.in_ready   = w_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign count          = r_count;
   assign done           = (r_state == ST_DONE);
   assign err            = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4, BASE=0x40) with hand-computed words.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam int ADDR_W = 10;
   localparam int BASE   = 64;
   localparam int DEPTH  = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [ADDR_W:0] count;
   logic            done;
   logic            err;
   int              checks = 0;
   int              errors = 0;
   int              acc, wr;
   logic            fire_in, fire_w;

   instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder #(.ADDR_W(ADDR_W), .BASE(BASE), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bus   (bus),
      .count (count),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      #1;
   endtask

   task automatic set_fields(input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] imm);
      bus.in_cls    = cls;
      bus.in_funct3 = f3;
      bus.in_funct7 = f7;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_rd     = rd;
      bus.in_imm    = imm;
   endtask

   // Offers one bundle and returns at accept edge + 1.
   task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm);
      int n;
      set_fields(cls, f3, f7, rs1, rs2, rd, imm);
      bus.in_valid = 1'b1;
      n = 0;
      #1;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         errors++;
         $display("FAIL send_timeout: in_ready never rose within 50 cycles");
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      bus.in_valid   = 1'b0;
      bus.imem_ready = 1'b1;
      set_fields(3'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we",    bus.imem_we, 1'b0);
      chk("rst_wdata", bus.imem_wdata, 32'h0);
      chk("rst_addr",  bus.imem_addr, 12'd64);
      chk("rst_count", count, 0);
      chk("rst_done",  done, 1'b0);
      chk("rst_err",   err, 1'b0);
      chk("rst_ready", bus.in_ready, 1'b0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle_ready", bus.in_ready, 1'b0);

      pulse_start();
      chk("run_ready", bus.in_ready, 1'b1);

      // R: ADD x3,x1,x2
      send(CLS_R, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
      chk("add_we",    bus.imem_we, 1'b1);
      chk("add_word",  bus.imem_wdata, 32'h002081B3);
      chk("add_addr",  bus.imem_addr, 12'd64);
      chk("add_count", count, 0);
      @(posedge clk); #1;
      chk("add_cmpl_count", count, 1);
      chk("add_cmpl_addr",  bus.imem_addr, 12'd68);
      chk("add_cmpl_we",    bus.imem_we, 1'b0);

      // I2: ADDI x5,x0,-1
      send(CLS_I2, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF);
      chk("addi_word", bus.imem_wdata, 32'hFFF00293);
      chk("addi_addr", bus.imem_addr, 12'd68);
      @(posedge clk); #1;

      // S: SW x2,8(x1)
      send(CLS_S, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
      chk("sw_word", bus.imem_wdata, 32'h0020A423);
      chk("sw_addr", bus.imem_addr, 12'd72);
      @(posedge clk); #1;
      chk("sw_count", count, 3);

      // B: BEQ x1,x2,-4 fills the last slot
      send(CLS_B, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC);
      chk("beq_word",  bus.imem_wdata, 32'hFE208EE3);
      chk("beq_addr",  bus.imem_addr, 12'd76);
      chk("beq_full_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      chk("full_count", count, 4);
      chk("full_done",  done, 1'b1);
      chk("full_ready", bus.in_ready, 1'b0);

      pulse_start();
      chk("restart_count", count, 0);
      chk("restart_done",  done, 1'b0);
      chk("restart_addr",  bus.imem_addr, 12'd64);

      // Backpressure: MUL x3,x1,x2 held for 5 cycles
      bus.imem_ready = 1'b0;
      send(CLS_R, 3'd0, F7_MUL, 5'd1, 5'd2, 5'd3, 32'd0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_we",    bus.imem_we, 1'b1);
         chk("bp_word",  bus.imem_wdata, 32'h022081B3);
         chk("bp_addr",  bus.imem_addr, 12'd64);
         chk("bp_ready", bus.in_ready, 1'b0);
         chk("bp_count", count, 0);
         @(posedge clk); #1;
      end
      bus.imem_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_count", count, 1);
      chk("bp_release_addr",  bus.imem_addr, 12'd68);

      // Illegal class mid-stream, then JAL x1,8 lands at the next address
      send(3'd7, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
      chk("ill_we",    bus.imem_we, 1'b0);
      chk("ill_err",   err, 1'b1);
      chk("ill_count", count, 1);
      chk("ill_addr",  bus.imem_addr, 12'd68);
      send(CLS_J, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8);
      chk("jal_word", bus.imem_wdata, 32'h008000EF);
      chk("jal_addr", bus.imem_addr, 12'd68);
      chk("jal_err",  err, 1'b1);
      @(posedge clk); #1;
      chk("jal_count", count, 2);

      // Out-of-range branch offset
      pulse_start();
      chk("start_err_clr", err, 1'b0);
      send(CLS_B, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd4096);
`ifdef IMM_RANGE_CHECK_EN
      chk("brange_we",  bus.imem_we, 1'b0);
      chk("brange_err", err, 1'b1);
`else
      chk("btrunc_we",   bus.imem_we, 1'b1);
      chk("btrunc_word", bus.imem_wdata, 32'h80208063);
      chk("btrunc_err",  err, 1'b0);
`endif
      @(posedge clk); #1;

      // Load: LB x6,16(x2)
      pulse_start();
      send(CLS_I1, F3_LDB, 7'd0, 5'd2, 5'd0, 5'd6, 32'd16);
      chk("lb_word", bus.imem_wdata, 32'h01010303);
      @(posedge clk); #1;

      // Stream 6 ADDI bundles back-to-back; only DEPTH land
      pulse_start();
      acc = 0;
      wr  = 0;
      set_fields(CLS_I2, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         fire_in = bus.in_valid && bus.in_ready;
         fire_w  = bus.imem_we && bus.imem_ready;
         if (fire_w) begin
            chk("stream_addr", bus.imem_addr, 64'(BASE + 4 * wr));
            chk("stream_word", bus.imem_wdata,
                64'(((wr + 1) << 20) | ((wr + 1) << 7) | 32'h13));
            wr++;
         end
         @(posedge clk); #1;
         if (fire_in) begin
            acc++;
            set_fields(CLS_I2, 3'd0, 7'd0, 5'd0, 5'd0, 5'(acc + 1), 32'(acc + 1));
         end
      end
      chk("stream_accepts", acc, DEPTH);
      chk("stream_writes",  wr, DEPTH);
      chk("stream_done",    done, 1'b1);
      chk("stream_ready",   bus.in_ready, 1'b0);
      chk("stream_count",   count, 4);
      bus.in_valid = 1'b0;
      pulse_start();
      chk("stream_restart_count", count, 0);

      // start while a word is pending discards it
      bus.imem_ready = 1'b0;
      send(CLS_R, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
      @(posedge clk); #1;
      pulse_start();
      chk("pend_start_we",    bus.imem_we, 1'b0);
      chk("pend_start_addr",  bus.imem_addr, 12'd64);
      chk("pend_start_count", count, 0);

      // Async reset mid-load
      send(CLS_R, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("areset_we",    bus.imem_we, 1'b0);
      chk("areset_wdata", bus.imem_wdata, 32'h0);
      chk("areset_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      bus.imem_ready = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
